// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: scoreboard entry layout,
// FSM state encoding and the "read from register file" forwarding select.
package hazard_pkg;

    // Widest register address a scoreboard entry can hold; narrower
    // addresses are zero-extended on the way in.
    localparam int MAX_AW = 8;

    // Forwarding select value meaning "take the operand from the register file".
    localparam int FWD_RF = 0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_e;

    // One in-flight instruction as seen by the hazard unit.
    typedef struct packed {
        logic              v;
        logic [MAX_AW-1:0] rw;
        logic              regwr;
        logic              load;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Youngest-match priority encoder for one source operand over the scoreboard.
// Entry 0 is the youngest (EX); the lowest matching index wins.
module sb_match
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int IW    = $clog2(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] i_entries,
    input  logic [MAX_AW-1:0]     i_addr,
    input  logic                  i_use,
    output logic                  o_hit,
    output logic [IW-1:0]         o_idx,
    output logic                  o_load
);

    // Scan oldest to youngest so the youngest matching entry overwrites the result.
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        o_hit  = 1'b0;
        o_idx  = '0;
        o_load = 1'b0;
        if (i_use && (i_addr != '0)) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (i_entries[i].v && i_entries[i].regwr && (i_entries[i].rw == i_addr)) begin
                    o_hit  = 1'b1;
                    o_idx  = IW'(i);
                    o_load = i_entries[i].load;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage MIPS pipeline, sitting beside ID.
// Tracks DEPTH downstream stages (entry 0 = EX .. DEPTH-1 = WB) and produces
// the IF/ID stall, per-operand forwarding selects and the branch flush.
// Build option: define FWD_EN to enable forwarding; without it every hazard
// waits until the producer reaches the WB entry (register file writes in the
// first half-cycle) and the forwarding selects stay at 0.
// Parameter limits: DEPTH >= 2, 2**SW > DEPTH, 1 <= BR_PENALTY <= 7, AW <= MAX_AW.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int AW         = 5,
    parameter int DEPTH      = 3,
    parameter int BR_PENALTY = 2,
    parameter int SW         = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [AW-1:0] id_rw,
    input  logic          id_regwr,
    input  logic          id_is_load,
    input  logic          ex_br_taken,
    output logic          if_stall,
    output logic          id_stall,
    output logic          flush,
    output logic [SW-1:0] fwd_a_sel,
    output logic [SW-1:0] fwd_b_sel,
    output logic [15:0]   stall_cnt
);

    localparam int IW   = $clog2(DEPTH);
    localparam int LAST = DEPTH - 1;

`ifdef FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    sb_entry_t [DEPTH-1:0] r_sb;
    hz_state_e             r_state;
    hz_state_e             w_state_nxt;
    logic [2:0]            r_flush_cnt;
    logic [2:0]            w_flush_cnt_nxt;
    logic [15:0]           r_stall_cnt;

    logic [MAX_AW-1:0]     w_rs;
    logic [MAX_AW-1:0]     w_rt;
    logic [MAX_AW-1:0]     w_rw;
    logic                  w_hit_a;
    logic                  w_hit_b;
    logic [IW-1:0]         w_idx_a;
    logic [IW-1:0]         w_idx_b;
    logic                  w_load_a;
    logic                  w_load_b;
    logic                  w_haz_a;
    logic                  w_haz_b;
    logic                  w_hazard;
    logic [SW-1:0]         w_sel_a;
    logic [SW-1:0]         w_sel_b;
    logic                  w_flush;
    logic                  w_stall;
    logic                  w_insert;
    sb_entry_t             w_new;

    assign w_rs = MAX_AW'(id_rs);
    assign w_rt = MAX_AW'(id_rt);
    assign w_rw = MAX_AW'(id_rw);

    sb_match #(.DEPTH(DEPTH), .IW(IW)) u_match_a (
        .i_entries (r_sb),
        .i_addr    (w_rs),
        .i_use     (id_use_rs),
        .o_hit     (w_hit_a),
        .o_idx     (w_idx_a),
        .o_load    (w_load_a)
    );

    sb_match #(.DEPTH(DEPTH), .IW(IW)) u_match_b (
        .i_entries (r_sb),
        .i_addr    (w_rt),
        .i_use     (id_use_rt),
        .o_hit     (w_hit_b),
        .o_idx     (w_idx_b),
        .o_load    (w_load_b)
    );

    // With forwarding only a load still in EX blocks; without it anything short of WB blocks.
    assign w_haz_a = w_hit_a && (FWD_ON ? ((w_idx_a == '0) && w_load_a) : (w_idx_a != IW'(LAST)));
    assign w_haz_b = w_hit_b && (FWD_ON ? ((w_idx_b == '0) && w_load_b) : (w_idx_b != IW'(LAST)));
    assign w_hazard = w_haz_a || w_haz_b;

    assign w_sel_a = (FWD_ON && w_hit_a && !w_haz_a) ? (SW'(w_idx_a) + SW'(1)) : SW'(FWD_RF);
    assign w_sel_b = (FWD_ON && w_hit_b && !w_haz_b) ? (SW'(w_idx_b) + SW'(1)) : SW'(FWD_RF);

    // Next-state and stall/flush decode: a taken branch or an active flush masks hazards.
    always_comb begin
        w_state_nxt     = ST_RUN;
        w_flush_cnt_nxt = r_flush_cnt;
        w_flush         = 1'b0;
        w_stall         = 1'b0;
        if (ex_br_taken) begin
            // The branch cycle itself is the first flush cycle.
            w_flush         = 1'b1;
            w_flush_cnt_nxt = 3'(BR_PENALTY - 1);
            w_state_nxt     = (BR_PENALTY > 1) ? ST_FLUSH : ST_RUN;
        end else begin
            case (r_state)
                ST_FLUSH: begin
                    w_flush         = 1'b1;
                    w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                    w_state_nxt     = (r_flush_cnt <= 3'd1) ? ST_RUN : ST_FLUSH;
                end
                default: begin
                    w_stall     = w_hazard;
                    w_state_nxt = w_hazard ? ST_STALL : ST_RUN;
                end
            endcase
        end
    end

    assign w_insert = id_valid && !w_stall && !w_flush;

    // Build the entry that enters EX next cycle (a bubble unless ID really issues).
    always_comb begin
        w_new = '0;
        if (w_insert) begin
            w_new.v     = 1'b1;
            w_new.rw    = w_rw;
            w_new.regwr = id_regwr;
            w_new.load  = id_is_load;
        end
    end

    // Shift the scoreboard one stage per cycle.
    always_ff @(posedge clk) begin
        // NOTE: the scoreboard is a small set of flops, so it is cleared in reset;
        // a stale valid bit would otherwise stall or forward from a phantom producer.
        if (!rst_n) begin
            r_sb <= '0;
        end else begin
            r_sb <= {r_sb[DEPTH-2:0], w_new};
        end
    end

    // FSM state and flush down-counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // Saturating count of stall cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (id_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    // Reset has top priority, so stall and flush are masked while it is held.
    assign flush     = rst_n && w_flush;
    assign if_stall  = rst_n && w_stall;
    assign id_stall  = rst_n && w_stall;
    assign fwd_a_sel = w_sel_a;
    assign fwd_b_sel = w_sel_b;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard (DEPTH=3, BR_PENALTY=2).
// Model: per-register age of the latest in-flight writer plus a flush countdown.
// Works with FWD_EN defined or undefined.
module tb_hazard_scoreboard;

    localparam int AW            = 5;
    localparam int DEPTH         = 3;
    localparam int BR_PENALTY    = 2;
    localparam int SW            = 2;
    localparam int NOT_IN_FLIGHT = 99;

`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic [AW-1:0] id_rw;
    logic          id_regwr;
    logic          id_is_load;
    logic          ex_br_taken;
    logic          if_stall;
    logic          id_stall;
    logic          flush;
    logic [SW-1:0] fwd_a_sel;
    logic [SW-1:0] fwd_b_sel;
    logic [15:0]   stall_cnt;

    hazard_scoreboard #(
        .AW(AW), .DEPTH(DEPTH), .BR_PENALTY(BR_PENALTY), .SW(SW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_rw       (id_rw),
        .id_regwr    (id_regwr),
        .id_is_load  (id_is_load),
        .ex_br_taken (ex_br_taken),
        .if_stall    (if_stall),
        .id_stall    (id_stall),
        .flush       (flush),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_age [32];      // cycles since latest writer of reg entered EX
    bit m_ld  [32];      // that writer is a load
    int m_flush_rem;     // flush cycles still owed after the branch cycle
    int m_cnt;           // expected stall_cnt
    bit m_exp_stall;     // model stall decision for the current cycle

    function automatic void op_eval(input logic [4:0] addr, input logic use_bit,
                                    output bit haz, output int sel);
        haz = 1'b0;
        sel = 0;
        if (use_bit && (addr != 5'd0) && (m_age[addr] < DEPTH)) begin
            if (FWD) begin
                if ((m_age[addr] == 0) && m_ld[addr]) haz = 1'b1;
                else sel = m_age[addr] + 1;
            end else begin
                haz = (m_age[addr] < DEPTH - 1);
            end
        end
    endfunction

    function automatic void model_eval(output bit e_flush, output bit e_stall,
                                       output int e_sa, output int e_sb);
        bit ha;
        bit hb;
        op_eval(id_rs, id_use_rs, ha, e_sa);
        op_eval(id_rt, id_use_rt, hb, e_sb);
        e_flush = rst_n && (ex_br_taken || (m_flush_rem > 0));
        e_stall = rst_n && !e_flush && (ha || hb);
    endfunction

    // Model update on the active edge.
    always @(posedge clk) begin
        bit ef;
        bit es;
        int sa;
        int sb;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_age[i] <= NOT_IN_FLIGHT;
                m_ld[i]  <= 1'b0;
            end
            m_flush_rem <= 0;
            m_cnt       <= 0;
        end else begin
            model_eval(ef, es, sa, sb);
            for (int i = 0; i < 32; i++)
                m_age[i] <= (m_age[i] >= NOT_IN_FLIGHT) ? NOT_IN_FLIGHT : m_age[i] + 1;
            if (id_valid && !es && !ef && id_regwr && (id_rw != 5'd0)) begin
                m_age[id_rw] <= 0;
                m_ld[id_rw]  <= id_is_load;
            end
            if (ex_br_taken) m_flush_rem <= BR_PENALTY - 1;
            else if (m_flush_rem > 0) m_flush_rem <= m_flush_rem - 1;
            if (es && (m_cnt < 65535)) m_cnt <= m_cnt + 1;
        end
    end

    // Compare process: every cycle out of reset, mid-cycle.
    always @(negedge clk) begin
        bit ef;
        bit es;
        int sa;
        int sb;
        if (chk_en && rst_n) begin
            model_eval(ef, es, sa, sb);
            m_exp_stall <= es;
            check("flush",     32'(flush),     32'(ef));
            check("if_stall",  32'(if_stall),  32'(es));
            check("id_stall",  32'(id_stall),  32'(es));
            check("fwd_a_sel", 32'(fwd_a_sel), 32'(sa));
            check("fwd_b_sel", 32'(fwd_b_sel), 32'(sb));
            check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int v, input int rs, input int rt, input int urs, input int urt,
                         input int rw, input int wr, input int ld, input int br);
        @(posedge clk);
        #1;
        id_valid    = 1'(v);
        id_rs       = 5'(rs);
        id_rt       = 5'(rt);
        id_use_rs   = 1'(urs);
        id_use_rt   = 1'(urt);
        id_rw       = 5'(rw);
        id_regwr    = 1'(wr);
        id_is_load  = 1'(ld);
        ex_br_taken = 1'(br);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Present an instruction in ID and hold it while it is stalled.
    task automatic run_instr(input int rs, input int rt, input int urs, input int urt,
                             input int rw, input int wr, input int ld,
                             output int stalls, output int sa, output int sb);
        bit timed_out;
        timed_out = 1'b1;
        stalls    = 0;
        drive(1, rs, rt, urs, urt, rw, wr, ld, 0);
        for (int k = 0; k < 8; k++) begin
            sample();
            if (id_stall === 1'b1) stalls++;
            if (!m_exp_stall) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        sa = int'(fwd_a_sel);
        sb = int'(fwd_b_sel);
        check("hold_bound", 32'(timed_out), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int sa;
        int sb;
        rst_n       = 1'b0;
        id_valid    = 1'b0;
        id_rs       = '0;
        id_rt       = '0;
        id_use_rs   = 1'b0;
        id_use_rt   = 1'b0;
        id_rw       = '0;
        id_regwr    = 1'b0;
        id_is_load  = 1'b0;
        ex_br_taken = 1'b0;
        m_exp_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Reset state
        sample();
        check("rst_if_stall",  32'(if_stall),  32'd0);
        check("rst_flush",     32'(flush),     32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);

        // 1: add $3,$1,$2 ; add $4,$3,$3
        run_instr(1, 2, 1, 1, 3, 1, 0, st, sa, sb);
        run_instr(3, 3, 1, 1, 4, 1, 0, st, sa, sb);
        check("t1_stalls", 32'(st), FWD ? 32'd0 : 32'd2);
        check("t1_fwd_a",  32'(sa), FWD ? 32'd1 : 32'd0);
        check("t1_fwd_b",  32'(sb), FWD ? 32'd1 : 32'd0);
        idle(3);

        // 2: lw $5,0($1) ; add $6,$5,$2
        run_instr(1, 0, 1, 0, 5, 1, 1, st, sa, sb);
        run_instr(5, 2, 1, 1, 6, 1, 0, st, sa, sb);
        check("t2_stalls", 32'(st), FWD ? 32'd1 : 32'd2);
        check("t2_fwd_a",  32'(sa), FWD ? 32'd2 : 32'd0);
        check("t2_fwd_b",  32'(sb), 32'd0);
        idle(1);
        sample();
        check("t2_stall_cnt", 32'(stall_cnt), FWD ? 32'd1 : 32'd4);
        idle(2);

        // 3: lw $7 ; taken branch while a $7 reader is in ID ; insert attempt during flush
        run_instr(1, 0, 1, 0, 7, 1, 1, st, sa, sb);
        drive(1, 7, 2, 1, 1, 9, 1, 0, 1);
        sample();
        check("t3_flush_c1", 32'(flush),    32'd1);
        check("t3_stall_c1", 32'(id_stall), 32'd0);
        drive(1, 0, 0, 0, 0, 8, 1, 0, 0);
        sample();
        check("t3_flush_c2", 32'(flush),    32'd1);
        drive(1, 8, 7, 1, 1, 10, 1, 0, 0);
        sample();
        check("t3_flush_c3", 32'(flush),     32'd0);
        check("t3_stall_c3", 32'(id_stall),  32'd0);
        check("t3_fwd_a_c3", 32'(fwd_a_sel), 32'd0);
        check("t3_fwd_b_c3", 32'(fwd_b_sel), FWD ? 32'd3 : 32'd0);
        idle(3);

        // 3b: branch taken again during flush reloads the counter
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        sample();
        check("t3b_flush_0", 32'(flush), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        sample();
        check("t3b_flush_1", 32'(flush), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        check("t3b_flush_2", 32'(flush), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        check("t3b_flush_3", 32'(flush), 32'd0);
        idle(2);

        // 4: write $0 then read $0
        run_instr(1, 2, 1, 1, 0, 1, 0, st, sa, sb);
        run_instr(0, 0, 1, 1, 11, 1, 0, st, sa, sb);
        check("t4_stalls", 32'(st), 32'd0);
        check("t4_fwd_a",  32'(sa), 32'd0);
        check("t4_fwd_b",  32'(sb), 32'd0);
        idle(3);

        // 6: reset in the middle of a load-use stall
        run_instr(1, 0, 1, 0, 5, 1, 1, st, sa, sb);
        drive(1, 5, 2, 1, 1, 6, 1, 0, 0);
        sample();
        check("t6_stall_pre", 32'(id_stall), 32'd1);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sample();
        check("t6_if_stall",  32'(if_stall),  32'd0);
        check("t6_id_stall",  32'(id_stall),  32'd0);
        check("t6_flush",     32'(flush),     32'd0);
        check("t6_fwd_a",     32'(fwd_a_sel), 32'd0);
        check("t6_fwd_b",     32'(fwd_b_sel), 32'd0);
        check("t6_stall_cnt", 32'(stall_cnt), 32'd0);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised hazard unit for the 5-stage MIPS pipeline. It replaces the current stub stall logic with a real scoreboard of in-flight destination registers, and sits beside the ID stage.
- Generates IF/ID stall, per-operand forwarding selects and branch flush.
- Tracks DEPTH downstream stages (EX..WB) so deeper pipelines reuse it unchanged.

Parameters:
AW, 5, register-address width
DEPTH, 3, number of tracked downstream stages (entry 0 = EX, entry DEPTH-1 = WB); min 2
BR_PENALTY, 2, cycles of flush after a taken branch resolves in EX; 1..7
SW, 2, width of forwarding selects; must satisfy 2^SW > DEPTH

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs  in  AW  source A address
id_rt  in  AW  source B address
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_rw  in  AW  destination address (after RegDst mux)
id_regwr  in  1  instruction writes register file
id_is_load  in  1  instruction is lw
ex_br_taken  in  1  branch in EX resolved taken this cycle
if_stall  out  1  hold PC and IF/ID register
id_stall  out  1  insert bubble into ID/EX
flush  out  1  squash IF/ID and ID/EX contents
fwd_a_sel  out  SW  0 = regfile, k = result of entry k-1
fwd_b_sel  out  SW  same for rt
stall_cnt  out  16  saturating count of stall cycles

Behaviour:
- Scoreboard: DEPTH entries {v, rw, regwr, load}, shifted every cycle: entry[i] <= entry[i-1].
  - entry[0] <= ID instruction only if id_valid & !id_stall & !flush; otherwise a bubble (v=0).
  - Entries with rw==0 or regwr==0 never match.
- Match for an operand (rs or rt with its use bit set, address != 0): youngest valid entry i with rw == operand.
  - fwd_x_sel = i+1 when forwarding is allowed, else 0.
  - Forwarding selects are combinational from the current scoreboard and ID inputs.
- Load-use: match at entry 0 with load=1 -> if_stall=id_stall=1 for exactly 1 cycle.
  - Next cycle the producer is at entry 1 and forwards normally (fwd sel = 2).
- FSM states:
  - RUN: normal operation.
  - STALL: load-use or no-forward wait, while a hazard persists.
  - FLUSH: flush=1 for BR_PENALTY cycles via a 3-bit down-counter loaded on ex_br_taken.
- Priority: reset > ex_br_taken/FLUSH > STALL > RUN.
  - In FLUSH, if_stall=id_stall=0 and hazards are ignored, since squashed instructions must not stall.
  - ex_br_taken during FLUSH reloads the counter.
- Counter expiry returns to RUN and re-evaluates hazards in that same cycle.
- stall_cnt increments each cycle id_stall=1 and saturates at 16'hFFFF.
- Reset (any cycle, including mid-stall or mid-flush):
  - all entries v=0, state RUN, counter 0, stall_cnt 0;
  - all outputs 0 in the cycle after the reset edge.
- Outputs if_stall and id_stall are always equal; both are kept as separate ports for future split stalls.

Optional Feature:
FWD_EN. When defined, forwarding is enabled as above. When undefined:
- fwd_a_sel/fwd_b_sel are tied to 0;
- any match at any entry i < DEPTH-1 stalls until the producer reaches entry DEPTH-1;
- the register file writes in the first half-cycle, so the WB entry needs no stall.
The maximum stall per hazard is DEPTH-1 cycles.

Decomposition:
- Shared package hazard_pkg holds:
  - the scoreboard entry typedef (v, rw, regwr, load);
  - FSM state encoding (RUN=0, STALL=1, FLUSH=2);
  - FWD_RF=0 select constant.
- One natural sub-module, sb_match: a combinational youngest-match priority encoder over DEPTH entries for one operand. It is instantiated twice, for rs and rt.

Test Plan:
1. add $3,$1,$2 then add $4,$3,$3 (FWD_EN) -> no stall; fwd_a_sel=fwd_b_sel=1 on the second instruction.
2. lw $5,0($1) then add $6,$5,$2 -> if_stall=id_stall=1 for one cycle, then fwd_a_sel=2; stall_cnt=1.
3. beq taken with ex_br_taken pulsed 1 cycle, BR_PENALTY=2 -> flush=1 for exactly 2 cycles.
   - Concurrent load-use in ID is ignored (id_stall=0).
   - No entries inserted during flush.
4. Producer writes $0 followed by a reader of $0 -> no stall; sel=0.
5. FWD_EN undefined, DEPTH=3: add $3 then immediate reader of $3 -> stall 2 cycles, then proceed with sel=0.
6. rst_n=0 asserted in the middle of case 2 stall -> next cycle all outputs 0, stall_cnt=0, scoreboard empty (a following reader of $5 does not stall).
